// File: rtl/xor_parity_pkg.sv
// Purpose: shared types and constants for the XOR-parity serial receiver.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package xor_parity_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    // Parity sense selectors.
    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    // Clock-counter value at which the start bit is sampled (centre of the bit).
    function automatic int unsigned mid_bit_idx(input int unsigned clks_per_bit);
        return (clks_per_bit / 2) - 1;
    endfunction

endpackage

// File: rtl/xor_parity_rx_sync.sv
// Purpose: two-flop synchroniser for the asynchronous serial line; resets to idle-high.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
module rx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the line; reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/xor_parity_rx.sv
// Purpose: serial frame receiver (start, DATA_W data LSB first, parity, stop) with XOR parity check.
// Latency: data_valid (DATA_W+2)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles after the start edge.
// Backpressure: none; consumer must take data_out on the one-cycle data_valid pulse.
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] MID_IDX  = CNT_W'(mid_bit_idx(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic rx_s;

    rx_state_e         state_q,    state_d;
    logic [CNT_W-1:0]  clk_cnt_q,  clk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic              acc_q,      acc_d;
    logic              mis_q,      mis_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              dv_q,       dv_d;
    logic              perr_q,     perr_d;
    logic              ferr_q,     ferr_d;

    logic start_smp;
    logic bit_smp;

    rx_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_in),
        .q_o (rx_s)
    );

    // Start bit is checked half a bit in; every later bit is one full bit after the previous sample.
    assign start_smp = (clk_cnt_q == MID_IDX);
    assign bit_smp   = (clk_cnt_q == LAST_IDX);

    // Next-state and datapath: sampling, shifting, parity accumulation and frame completion.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        mis_d      = mis_q;
        data_out_d = data_out_q;
        dv_d       = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    acc_d     = 1'b0;
                end
            end
            START: begin
                if (start_smp) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_smp) begin
                    clk_cnt_d          = '0;
                    shift_d            = shift_q >> 1;
                    shift_d[DATA_W-1]  = rx_s;
                    acc_d              = acc_q ^ rx_s;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_smp) begin
                    clk_cnt_d = '0;
                    mis_d     = ((acc_q ^ rx_s) != PARITY_ODD);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_smp) begin
                    clk_cnt_d  = '0;
                    dv_d       = 1'b1;
                    data_out_d = shift_q;
                    perr_d     = mis_q;
                    ferr_d     = !rx_s;
                    // A low stop bit means the line may be stuck low; wait for it to recover.
                    state_d    = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            acc_q      <= 1'b0;
            mis_q      <= 1'b0;
            data_out_q <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            mis_q      <= mis_d;
            data_out_q <= data_out_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_xor_parity_rx.sv
// Purpose: directed self-checking bench for xor_parity_rx (even-parity and odd-parity instances).
// Latency: checks the start-edge to data_valid latency and back-to-back pulse spacing.
// Backpressure: none; outputs are sampled #1 after the rising edge or on the falling edge.
module tb_xor_parity_rx;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          rx_a = 1'b1;
    logic          rx_b = 1'b1;

    logic [DW-1:0] dout_a, dout_b;
    logic          dv_a, dv_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_a),
        .data_out   (dout_a),
        .data_valid (dv_a),
        .parity_err (perr_a),
        .frame_err  (ferr_a),
        .busy       (busy_a)
    );

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_b),
        .data_out   (dout_b),
        .data_valid (dv_b),
        .parity_err (perr_b),
        .frame_err  (ferr_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors: count data_valid cycles and log when/what they carried.
    int          a_cnt = 0;
    int          a_cyc = 0;
    int          b_cnt = 0;
    int          b_cyc [2];
    logic [7:0]  b_dat [2];
    logic        b_perr[2];

    always @(negedge clk) begin
        if (dv_a) begin
            a_cnt <= a_cnt + 1;
            a_cyc <= cyc;
        end
        if (dv_b) begin
            if (b_cnt < 2) begin
                b_cyc[b_cnt]  <= cyc;
                b_dat[b_cnt]  <= dout_b;
                b_perr[b_cnt] <= perr_b;
            end
            b_cnt <= b_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic b, input int n);
        if (sel) rx_b = b;
        else     rx_a = b;
        tick(n);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic p, input logic s);
        drive(sel, 1'b0, CPB);
        for (int i = 0; i < DW; i++) drive(sel, d[i], CPB);
        drive(sel, p, CPB);
        drive(sel, s, CPB);
    endtask

    initial begin
        int n0;
        int c0;
        logic [7:0] c3;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_data_out", dout_a, 8'h00);
        chk("rst_valid",    dv_a,   1'b0);
        chk("rst_perr",     perr_a, 1'b0);
        chk("rst_ferr",     ferr_a, 1'b0);
        chk("rst_busy",     busy_a, 1'b0);
        chk("rst_busy_odd", busy_b, 1'b0);
        rst = 1'b0;
        tick(4);

        // 1: clean 0xA5, latency 45 cycles from start edge
        n0 = a_cnt;
        c0 = cyc;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        chk("t1_busy_in_stop", busy_a, 1'b1);
        tick(4);
        chk("t1_pulses",  a_cnt - n0, 1);
        chk("t1_latency", a_cyc - c0, 45);
        chk("t1_data",    dout_a, 8'hA5);
        chk("t1_perr",    perr_a, 1'b0);
        chk("t1_ferr",    ferr_a, 1'b0);
        chk("t1_busy_after", busy_a, 1'b0);
        tick(4);

        // 2: 0x01 with wrong (even) parity
        n0 = a_cnt;
        send_frame(1'b0, 8'h01, 1'b0, 1'b1);
        tick(4);
        chk("t2_pulses", a_cnt - n0, 1);
        chk("t2_data",   dout_a, 8'h01);
        chk("t2_perr",   perr_a, 1'b1);
        chk("t2_ferr",   ferr_a, 1'b0);
        tick(4);

        // 3: 0x3C with low stop, line held low, then recovery and 0x5A
        n0 = a_cnt;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 20);
        chk("t3_pulses",    a_cnt - n0, 1);
        chk("t3_data",      dout_a, 8'h3C);
        chk("t3_ferr",      ferr_a, 1'b1);
        chk("t3_perr",      perr_a, 1'b0);
        chk("t3_busy_wait", busy_a, 1'b1);
        drive(1'b0, 1'b1, 6);
        chk("t3_busy_idle", busy_a, 1'b0);
        n0 = a_cnt;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        tick(4);
        chk("t3b_pulses", a_cnt - n0, 1);
        chk("t3b_data",   dout_a, 8'h5A);
        chk("t3b_ferr",   ferr_a, 1'b0);
        chk("t3b_perr",   perr_a, 1'b0);
        tick(4);

        // 4: one-cycle glitch is a false start
        n0 = a_cnt;
        drive(1'b0, 1'b0, 1);
        rx_a = 1'b1;
        tick(2);
        chk("t4_busy_start", busy_a, 1'b1);
        tick(10);
        chk("t4_busy_idle", busy_a, 1'b0);
        chk("t4_pulses",    a_cnt - n0, 0);
        chk("t4_data_held", dout_a, 8'h5A);

        // 5: reset during 4th data bit of 0xC3 aborts the frame; 0x81 follows
        n0 = a_cnt;
        c3 = 8'hC3;
        drive(1'b0, 1'b0, CPB);
        for (int i = 0; i < 3; i++) drive(1'b0, c3[i], CPB);
        drive(1'b0, c3[3], 2);
        rst  = 1'b1;
        rx_a = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_rst_data",  dout_a, 8'h00);
        chk("t5_rst_valid", dv_a,   1'b0);
        chk("t5_rst_perr",  perr_a, 1'b0);
        chk("t5_rst_ferr",  ferr_a, 1'b0);
        chk("t5_rst_busy",  busy_a, 1'b0);
        tick(50);
        chk("t5_no_pulse", a_cnt - n0, 0);
        n0 = a_cnt;
        send_frame(1'b0, 8'h81, 1'b0, 1'b1);
        tick(4);
        chk("t5_pulses", a_cnt - n0, 1);
        chk("t5_data",   dout_a, 8'h81);
        chk("t5_perr",   perr_a, 1'b0);
        chk("t5_ferr",   ferr_a, 1'b0);

        // 6: odd parity, back-to-back 0xFF and 0x00 with no idle gap
        n0 = b_cnt;
        send_frame(1'b1, 8'hFF, 1'b1, 1'b1);
        send_frame(1'b1, 8'h00, 1'b1, 1'b1);
        tick(6);
        chk("t6_pulses",  b_cnt - n0, 2);
        chk("t6_spacing", b_cyc[1] - b_cyc[0], 44);
        chk("t6_data0",   b_dat[0], 8'hFF);
        chk("t6_data1",   b_dat[1], 8'h00);
        chk("t6_perr0",   b_perr[0], 1'b0);
        chk("t6_perr1",   b_perr[1], 1'b0);
        chk("t6_ferr",    ferr_b, 1'b0);
        chk("t6_busy",    busy_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
